// File: rtl/wb_trace_checker.sv
// wb_trace_checker: in-order comparison of the core's register-writeback stream
// against an expected trace buffered in a small valid/ready FIFO.
module wb_trace_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       io_rd_final_rd_wb,
  input  logic             io_rd_final_rd_wb_en,
  input  logic [31:0]      io_rd_final_rd_wb_data,
  input  logic             io_exp_valid,
  output logic             io_exp_ready,
  input  logic [4:0]       io_exp_rd,
  input  logic [31:0]      io_exp_data,
  input  logic             io_exp_last,
  output logic [CNT_W-1:0] io_match_count,
  output logic             io_fail,
  output logic [1:0]       io_err_code,
  output logic [4:0]       io_fail_exp_rd,
  output logic [31:0]      io_fail_exp_data,
  output logic [4:0]       io_fail_got_rd,
  output logic [31:0]      io_fail_got_data,
  output logic             io_done
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_MISMATCH  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_OVERRUN   = 2'd3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        last;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DONE,
    ST_FAIL
  } state_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  state_t          r_state;
  logic            r_ready_en;

  logic [CNT_W-1:0] r_match_count;
  logic             r_fail;
  logic [1:0]       r_err_code;
  logic [4:0]       r_fail_exp_rd;
  logic [31:0]      r_fail_exp_data;
  logic [4:0]       r_fail_got_rd;
  logic [31:0]      r_fail_got_data;
  logic             r_done;

  entry_t w_head;
  logic   w_empty;
  logic   w_full;
  logic   w_wb;
  logic   w_match;
  logic   w_push;
  logic   w_pop;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_wb    = io_rd_final_rd_wb_en && (io_rd_final_rd_wb != 5'd0);
  assign w_match = !w_empty && (w_head.rd == io_rd_final_rd_wb)
                            && (w_head.data == io_rd_final_rd_wb_data);

  // r_ready_en holds ready low through reset and releases it one edge later.
  assign io_exp_ready = r_ready_en && !w_full && (r_state == ST_RUN);
  assign w_push       = io_exp_valid && io_exp_ready;
  assign w_pop        = (r_state == ST_RUN) && w_wb && w_match;

  // NOTE: the payload array is deliberately not reset; the pointers and level
  // alone decide which slots are valid, so it can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{rd: io_exp_rd, data: io_exp_data, last: io_exp_last};
    end
  end

  // NOTE: all state uses non-blocking assignments so every decision made on
  // this edge sees the values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_state         <= ST_RUN;
      r_ready_en      <= 1'b0;
      r_match_count   <= '0;
      r_fail          <= 1'b0;
      r_err_code      <= ERR_NONE;
      r_fail_exp_rd   <= '0;
      r_fail_exp_data <= '0;
      r_fail_got_rd   <= '0;
      r_fail_got_data <= '0;
      r_done          <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case (r_state)
        ST_RUN: begin
          if (w_wb) begin
            if (w_empty) begin
              // Nothing was expected yet: the core wrote back too early.
              r_state         <= ST_FAIL;
              r_fail          <= 1'b1;
              r_err_code      <= ERR_UNDERFLOW;
              r_fail_exp_rd   <= '0;
              r_fail_exp_data <= '0;
              r_fail_got_rd   <= io_rd_final_rd_wb;
              r_fail_got_data <= io_rd_final_rd_wb_data;
            end else if (w_match) begin
              r_match_count <= r_match_count + CNT_W'(1);
              if (w_head.last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              // Head stays in the FIFO so the failing entry remains inspectable.
              r_state         <= ST_FAIL;
              r_fail          <= 1'b1;
              r_err_code      <= ERR_MISMATCH;
              r_fail_exp_rd   <= w_head.rd;
              r_fail_exp_data <= w_head.data;
              r_fail_got_rd   <= io_rd_final_rd_wb;
              r_fail_got_data <= io_rd_final_rd_wb_data;
            end
          end
        end
        ST_DONE: begin
          if (w_wb) begin
            r_state         <= ST_FAIL;
            r_fail          <= 1'b1;
            r_err_code      <= ERR_OVERRUN;
            r_fail_exp_rd   <= '0;
            r_fail_exp_data <= '0;
            r_fail_got_rd   <= io_rd_final_rd_wb;
            r_fail_got_data <= io_rd_final_rd_wb_data;
          end
        end
        default: begin
          // FAIL is terminal; detail stays frozen until reset.
        end
      endcase
    end
  end

  assign io_match_count   = r_match_count;
  assign io_fail          = r_fail;
  assign io_err_code      = r_err_code;
  assign io_fail_exp_rd   = r_fail_exp_rd;
  assign io_fail_exp_data = r_fail_exp_data;
  assign io_fail_got_rd   = r_fail_got_rd;
  assign io_fail_got_data = r_fail_got_data;
  assign io_done          = r_done;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: directed stimulus pushes hand-computed
// expected output snapshots; a negedge monitor pops and compares them.
module tb_wb_trace_checker;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [4:0]        wb_rd;
  logic              wb_en;
  logic [31:0]       wb_data;
  logic              exp_valid;
  logic              exp_ready;
  logic [4:0]        exp_rd;
  logic [31:0]       exp_data;
  logic              exp_last;
  logic [CNT_W-1:0]  match_count;
  logic              fail;
  logic [1:0]        err_code;
  logic [4:0]        fail_exp_rd;
  logic [31:0]       fail_exp_data;
  logic [4:0]        fail_got_rd;
  logic [31:0]       fail_got_data;
  logic              done;

  wb_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_rd_final_rd_wb      (wb_rd),
    .io_rd_final_rd_wb_en   (wb_en),
    .io_rd_final_rd_wb_data (wb_data),
    .io_exp_valid           (exp_valid),
    .io_exp_ready           (exp_ready),
    .io_exp_rd              (exp_rd),
    .io_exp_data            (exp_data),
    .io_exp_last            (exp_last),
    .io_match_count         (match_count),
    .io_fail                (fail),
    .io_err_code            (err_code),
    .io_fail_exp_rd         (fail_exp_rd),
    .io_fail_exp_data       (fail_exp_data),
    .io_fail_got_rd         (fail_got_rd),
    .io_fail_got_data       (fail_got_data),
    .io_done                (done)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] cnt;
    logic        fail;
    logic [1:0]  code;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic [4:0]  grd;
    logic [31:0] gdata;
    logic        done;
    logic        ready;
  } snap_t;

  snap_t sb_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic check(input string name, input int unsigned c,
                       input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, c, got, want);
  endtask

  // Monitor: compare every snapshot due at this cycle.
  initial begin
    snap_t s;
    forever begin
      @(negedge clock);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        s = sb_q.pop_front();
        check("match_count", s.cyc, match_count, s.cnt);
        check("fail",        s.cyc, {31'd0, fail}, {31'd0, s.fail});
        check("err_code",    s.cyc, {30'd0, err_code}, {30'd0, s.code});
        check("fail_exp_rd", s.cyc, {27'd0, fail_exp_rd}, {27'd0, s.erd});
        check("fail_exp_data", s.cyc, fail_exp_data, s.edata);
        check("fail_got_rd", s.cyc, {27'd0, fail_got_rd}, {27'd0, s.grd});
        check("fail_got_data", s.cyc, fail_got_data, s.gdata);
        check("done",        s.cyc, {31'd0, done}, {31'd0, s.done});
        check("exp_ready",   s.cyc, {31'd0, exp_ready}, {31'd0, s.ready});
      end
    end
  end

  // Expected outputs after the coming edge.
  task automatic expect_st(input logic [31:0] cnt, input logic f, input logic [1:0] code,
                           input logic [4:0] erd, input logic [31:0] edata,
                           input logic [4:0] grd, input logic [31:0] gdata,
                           input logic d, input logic rdy);
    snap_t s;
    s.cyc = cyc + 1; s.cnt = cnt; s.fail = f; s.code = code;
    s.erd = erd; s.edata = edata; s.grd = grd; s.gdata = gdata;
    s.done = d; s.ready = rdy;
    sb_q.push_back(s);
  endtask

  task automatic expect_ok(input logic [31:0] cnt, input logic d, input logic rdy);
    expect_st(cnt, 1'b0, 2'd0, 5'd0, 32'd0, 5'd0, 32'd0, d, rdy);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    exp_valid = 1'b0; exp_rd = '0; exp_data = '0; exp_last = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic set_push(input logic [4:0] rd, input logic [31:0] d, input logic l);
    exp_valid = 1'b1; exp_rd = rd; exp_data = d; exp_last = l;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expect_ok(0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    expect_ok(0, 1'b0, 1'b1);
    step();
  endtask

  initial begin
    exp_valid = 1'b0; exp_rd = '0; exp_data = '0; exp_last = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    do_reset();

    // Three-entry trace matched back to back, then an overrun in DONE.
    set_push(5'd1, 32'h11, 1'b0); expect_ok(0, 1'b0, 1'b1); step();
    set_push(5'd2, 32'h22, 1'b0); expect_ok(0, 1'b0, 1'b1); step();
    set_push(5'd3, 32'h33, 1'b1); expect_ok(0, 1'b0, 1'b1); step();
    set_wb(5'd1, 32'h11); expect_ok(1, 1'b0, 1'b1); step();
    set_wb(5'd2, 32'h22); expect_ok(2, 1'b0, 1'b1); step();
    set_wb(5'd3, 32'h33); expect_ok(3, 1'b1, 1'b0); step();
    set_wb(5'd4, 32'h4);
    expect_st(3, 1'b1, 2'd3, 5'd0, 32'd0, 5'd4, 32'h4, 1'b1, 1'b0); step();
    do_reset();

    // New trace after reset: x0 writes ignored, push and pop in one cycle.
    set_push(5'd1, 32'h11, 1'b0); expect_ok(0, 1'b0, 1'b1); step();
    set_push(5'd2, 32'h22, 1'b1); set_wb(5'd1, 32'h11); expect_ok(1, 1'b0, 1'b1); step();
    set_wb(5'd0, 32'h1234); expect_ok(1, 1'b0, 1'b1); step();
    set_wb(5'd2, 32'h22); expect_ok(2, 1'b1, 1'b0); step();
    do_reset();

    // Data mismatch; later activity must not disturb the frozen detail.
    set_push(5'd5, 32'hDEADBEEF, 1'b0); expect_ok(0, 1'b0, 1'b1); step();
    set_wb(5'd5, 32'hDEADBEEE);
    expect_st(0, 1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEE, 1'b0, 1'b0); step();
    set_wb(5'd5, 32'hDEADBEEF); set_push(5'd6, 32'h66, 1'b1);
    expect_st(0, 1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEE, 1'b0, 1'b0); step();
    do_reset();

    // Underflow on an empty FIFO.
    set_wb(5'd7, 32'h1);
    expect_st(0, 1'b1, 2'd2, 5'd0, 32'd0, 5'd7, 32'h1, 1'b0, 1'b0); step();
    do_reset();

    // Push and writeback in the same cycle on an empty FIFO is still underflow.
    set_push(5'd9, 32'h99, 1'b1); set_wb(5'd9, 32'h99);
    expect_st(0, 1'b1, 2'd2, 5'd0, 32'd0, 5'd9, 32'h99, 1'b0, 1'b0); step();
    do_reset();

    // Fill to DEPTH; a push offered alongside the freeing pop is refused.
    for (int i = 1; i <= DEPTH; i++) begin
      set_push(5'(i), 32'(i), 1'b0);
      expect_ok(0, 1'b0, (i < DEPTH) ? 1'b1 : 1'b0);
      step();
    end
    set_wb(5'd1, 32'd1); set_push(5'd12, 32'hC, 1'b0); expect_ok(1, 1'b0, 1'b1); step();
    set_push(5'd9, 32'd9, 1'b1); expect_ok(1, 1'b0, 1'b0); step();
    for (int i = 2; i <= DEPTH; i++) begin
      set_wb(5'(i), 32'(i)); expect_ok(32'(i), 1'b0, 1'b1); step();
    end
    set_wb(5'd9, 32'd9); expect_ok(9, 1'b1, 1'b0); step();

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending snapshots expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
